iot_pio_arbiter: RTL and testbench
==================================

# iot_pio_arbiter

Shares one Avalon-MM PIO slave (2-bit address, 32-bit data, registered readdata) between `NUM_REQ` internal requesters. Each requester uses a valid/ready command port and gets a one-cycle response strobe. A round-robin arbiter grants requesters one at a time, and a small FSM sequences the single-cycle chipselect access and read-latency wait. It sits between firmware-side or hardware-side masters and the PIO instance in the IOT subsystem.

## Interface
Parameters:
- `NUM_REQ`, 2, number of requesters (≥2)
- `ADDR_W`, 2, PIO address width
- `DATA_W`, 32, PIO data width
- `READ_LATENCY`, 1, PIO cycles from address to valid readdata (≥1)

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high reset
- `req_valid`  in  NUM_REQ  command pending, per requester
- `req_write`  in  NUM_REQ  1 = write, 0 = read
- `req_address`  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- `req_writedata`  in  NUM_REQ*DATA_W  packed likewise
- `req_ready`  out  NUM_REQ  one-hot pulse: command accepted
- `rsp_valid`  out  NUM_REQ  one-hot pulse: access complete
- `rsp_readdata`  out  DATA_W  read result, valid with `rsp_valid`
- `pio_address`  out  ADDR_W  to PIO `address`
- `pio_chipselect`  out  1  to PIO `chipselect`
- `pio_write_n`  out  1  to PIO `write_n`, active-low
- `pio_writedata`  out  DATA_W  to PIO `writedata`
- `pio_readdata`  in  DATA_W  from PIO `readdata`

## Operation
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid`, pick a winner by round-robin, starting at `last_grant+1` mod NUM_REQ. Latch the winner's write/address/writedata and grant index, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE, exactly one cycle:
  - `pio_chipselect`=1; `pio_write_n`=~write; `req_ready[grant]`=1; `last_grant`←grant.
  - Write: next state RESP.
  - Read: load the wait counter with READ_LATENCY and go to WAIT.
- WAIT: `pio_chipselect`=0, and `pio_address` holds the latched address. The PIO re-registers readdata every clock, so the address must stay stable. The counter decrements each cycle. On the cycle where counter==1, capture `pio_readdata` into `rsp_readdata` and go to RESP.
- RESP, one cycle: `rsp_valid[grant]`=1, then go to IDLE. `rsp_readdata` holds its value until the next read capture; it is not defined for write responses.
- Requesters hold valid and fields stable until `req_ready`. The command is latched at grant, so later changes do not affect the access in flight.
- `pio_address`, `pio_writedata` and the latched command are registered. They change only on grant.

## Timing
- Reset values: state IDLE, `last_grant`=NUM_REQ-1 (requester 0 wins first), `pio_chipselect`=0, `pio_write_n`=1, `pio_address`=0, `pio_writedata`=0, `req_ready`=0, `rsp_valid`=0, `rsp_readdata`=0.
- Write: valid seen in IDLE at cycle 0, ISSUE at cycle 1 (PIO write occurs at the end of cycle 1), `rsp_valid` at cycle 2. Throughput is one write per 3 cycles.
- Read: ISSUE at cycle 1, WAIT at cycles 2..1+READ_LATENCY, `rsp_valid` at cycle 2+READ_LATENCY.
- Only one access is outstanding at a time. New requests are not sampled outside IDLE.
- Simultaneous requests: the winner is the first valid index after `last_grant`. A requester that stays valid cannot be granted twice in a row while another is valid.
- Reset asserted mid-operation (any state) immediately forces all reset values. Any in-flight response is dropped and no `rsp_valid` is emitted.
- `req_valid` deasserted after grant: the access still completes and `rsp_valid` still pulses.

## Structure
- Package `iot_pio_arb_pkg` holds the state enum (IDLE/ISSUE/WAIT/RESP) and the counter width constant, clog2(READ_LATENCY+1).
- Sub-module `iot_rr_arbiter`: a combinational round-robin pick. It takes `req_valid` and `last_grant` and returns the one-hot grant plus its index. It is reusable for other shared slaves.
- The top level contains the FSM, command latch, wait counter and response register.

## Test plan
- Write from requester 0, addr 0, data 0x5 → cycle 1: `pio_chipselect`=1, `pio_write_n`=0, `pio_writedata`=0x5, `req_ready`=01. Cycle 2: `rsp_valid`=01. PIO `out_port` = 0x5.
- Read from requester 1, addr 0, PIO `in_port`=0xA → `rsp_valid`=10 at cycle 3 with `rsp_readdata`=0x0000000A. Read from addr 1 → `rsp_readdata`=0.
- Both requesters valid from reset, continuously → grants alternate 0,1,0,1. Each requester is served within 2 transactions.
- Requester 0 alone back-to-back for 4 reads → served every 4 cycles with READ_LATENCY=1. `pio_address` is stable through every WAIT.
- Reset pulsed during WAIT → outputs return to reset values the same cycle, no `rsp_valid` appears, and the next grant goes to requester 0.
- READ_LATENCY=2 with NUM_REQ=3, all valid → `rsp_valid` at cycle 4 after each grant, and grants rotate 0,1,2.

Source files
------------

// File: rtl/iot_pio_arb_pkg.sv
// iot_pio_arb_pkg
// Shared types and sizing helpers for the PIO arbiter and its round-robin
// picker: the access FSM state encoding, the grant-index width and the
// read-latency counter width.
package iot_pio_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Width of a requester index; at least one bit even for degenerate counts.
  function automatic int idx_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  // Width of the wait counter, which must hold READ_LATENCY itself.
  function automatic int cnt_width(input int read_latency);
    return $clog2(read_latency + 1);
  endfunction

endpackage

// File: rtl/iot_rr_arbiter.sv
// iot_rr_arbiter
// Combinational round-robin pick. The search starts at last_grant+1 (mod
// NUM_REQ) so the previous winner has the lowest priority.
// Ports:
//   req_valid  in   per-requester pending flags
//   last_grant in   index of the most recently served requester
//   grant_oh   out  one-hot winner (all zero when nothing is pending)
//   grant_idx  out  binary index of the winner
//   grant_any  out  at least one requester is pending
module iot_rr_arbiter
  import iot_pio_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  always_comb begin : pick
    logic [IDX_W-1:0] cand;
    cand      = '0;
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    // off runs 1..NUM_REQ so last_grant itself is checked last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any      = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/iot_pio_arbiter.sv
// iot_pio_arbiter
// Shares one Avalon-MM PIO slave between NUM_REQ requesters. One access is
// in flight at a time: IDLE -> ISSUE (chipselect cycle) -> [WAIT x
// READ_LATENCY for reads] -> RESP (response strobe) -> IDLE.
//
// Handshake: a requester holds req_valid and its fields stable until it sees
// req_ready (a one-cycle pulse in the ISSUE cycle). The command is latched
// when it is granted, so the requester may drop or change its request from
// then on; the access still completes and rsp_valid pulses for one cycle.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   req_valid/write/address/writedata   packed per-requester commands
//   req_ready       one-hot accept pulse
//   rsp_valid       one-hot completion pulse
//   rsp_readdata    read result, valid with rsp_valid (held until next read)
//   pio_*           Avalon-MM PIO master side
//   dbg_state       current FSM state (iot_pio_arb_pkg::state_e encoding)
module iot_pio_arbiter
  import iot_pio_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_address,
  input  logic [NUM_REQ*DATA_W-1:0]  req_writedata,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [DATA_W-1:0]          rsp_readdata,
  output logic [ADDR_W-1:0]          pio_address,
  output logic                       pio_chipselect,
  output logic                       pio_write_n,
  output logic [DATA_W-1:0]          pio_writedata,
  input  logic [DATA_W-1:0]          pio_readdata,
  output logic [1:0]                 dbg_state
);

  localparam int IDX_W = idx_width(NUM_REQ);
  localparam int CNT_W = cnt_width(READ_LATENCY);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic                write_q, write_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   pio_address_q, pio_address_d;
  logic [DATA_W-1:0]   pio_writedata_q, pio_writedata_d;
  logic                pio_chipselect_q, pio_chipselect_d;
  logic                pio_write_n_q, pio_write_n_d;
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_readdata_q, rsp_readdata_d;

  logic [NUM_REQ-1:0]  arb_oh;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic [NUM_REQ-1:0]  grant_oh_q;

  iot_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_valid  (req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx),
    .grant_any  (arb_any)
  );

  assign grant_oh_q = NUM_REQ'(1) << grant_q;

  always_comb begin
    state_d          = state_q;
    last_grant_d     = last_grant_q;
    grant_d          = grant_q;
    write_d          = write_q;
    cnt_d            = cnt_q;
    pio_address_d    = pio_address_q;
    pio_writedata_d  = pio_writedata_q;
    rsp_readdata_d   = rsp_readdata_q;
    // Strobes default low so every pulse lasts exactly one cycle.
    pio_chipselect_d = 1'b0;
    pio_write_n_d    = 1'b1;
    req_ready_d      = '0;
    rsp_valid_d      = '0;

    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          grant_d          = arb_idx;
          write_d          = req_write[arb_idx];
          pio_address_d    = req_address[arb_idx*ADDR_W +: ADDR_W];
          pio_writedata_d  = req_writedata[arb_idx*DATA_W +: DATA_W];
          // Outputs for the ISSUE cycle are set up here so they are registered.
          pio_chipselect_d = 1'b1;
          pio_write_n_d    = ~req_write[arb_idx];
          req_ready_d      = arb_oh;
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        last_grant_d = grant_q;
        if (write_q) begin
          rsp_valid_d = grant_oh_q;
          state_d     = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(READ_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // pio_address is left untouched: the PIO re-registers readdata each
        // clock, so the address must stay put until the capture.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_readdata_d = pio_readdata;
          rsp_valid_d    = grant_oh_q;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      last_grant_q     <= IDX_W'(NUM_REQ - 1);
      grant_q          <= '0;
      write_q          <= 1'b0;
      cnt_q            <= '0;
      pio_address_q    <= '0;
      pio_writedata_q  <= '0;
      pio_chipselect_q <= 1'b0;
      pio_write_n_q    <= 1'b1;
      req_ready_q      <= '0;
      rsp_valid_q      <= '0;
      rsp_readdata_q   <= '0;
    end else begin
      state_q          <= state_d;
      last_grant_q     <= last_grant_d;
      grant_q          <= grant_d;
      write_q          <= write_d;
      cnt_q            <= cnt_d;
      pio_address_q    <= pio_address_d;
      pio_writedata_q  <= pio_writedata_d;
      pio_chipselect_q <= pio_chipselect_d;
      pio_write_n_q    <= pio_write_n_d;
      req_ready_q      <= req_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_readdata_q   <= rsp_readdata_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_readdata   = rsp_readdata_q;
  assign pio_address    = pio_address_q;
  assign pio_chipselect = pio_chipselect_q;
  assign pio_write_n    = pio_write_n_q;
  assign pio_writedata  = pio_writedata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_iot_pio_arbiter.sv
// tb_iot_pio_arbiter
// Directed bench for iot_pio_arbiter. Two instances share clock and reset:
// dut_a (NUM_REQ=2, READ_LATENCY=1) and dut_b (NUM_REQ=3, READ_LATENCY=2).
// Each drives a small PIO model: address 0 reads in_port, other addresses
// read 0; writes to address 0 update out_port. Readdata is registered with
// the matching latency.
module tb_iot_pio_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  // ---------------- dut_a signals ----------------
  logic [1:0]  a_req_valid, a_req_write, a_req_ready, a_rsp_valid;
  logic [3:0]  a_req_address;
  logic [63:0] a_req_writedata;
  logic [31:0] a_rsp_readdata, a_pio_writedata, a_pio_readdata;
  logic [1:0]  a_pio_address, a_dbg_state;
  logic        a_pio_chipselect, a_pio_write_n;
  logic [31:0] a_in_port, a_out_port;

  // ---------------- dut_b signals ----------------
  logic [2:0]  b_req_valid, b_req_write, b_req_ready, b_rsp_valid;
  logic [5:0]  b_req_address;
  logic [95:0] b_req_writedata;
  logic [31:0] b_rsp_readdata, b_pio_writedata, b_pio_readdata, b_pio_stage;
  logic [1:0]  b_pio_address, b_dbg_state;
  logic        b_pio_chipselect, b_pio_write_n;
  logic [31:0] b_in_port;

  iot_pio_arbiter #(
    .NUM_REQ(2), .ADDR_W(2), .DATA_W(32), .READ_LATENCY(1)
  ) dut_a (
    .clk            (clk),
    .reset          (rst),
    .req_valid      (a_req_valid),
    .req_write      (a_req_write),
    .req_address    (a_req_address),
    .req_writedata  (a_req_writedata),
    .req_ready      (a_req_ready),
    .rsp_valid      (a_rsp_valid),
    .rsp_readdata   (a_rsp_readdata),
    .pio_address    (a_pio_address),
    .pio_chipselect (a_pio_chipselect),
    .pio_write_n    (a_pio_write_n),
    .pio_writedata  (a_pio_writedata),
    .pio_readdata   (a_pio_readdata),
    .dbg_state      (a_dbg_state)
  );

  iot_pio_arbiter #(
    .NUM_REQ(3), .ADDR_W(2), .DATA_W(32), .READ_LATENCY(2)
  ) dut_b (
    .clk            (clk),
    .reset          (rst),
    .req_valid      (b_req_valid),
    .req_write      (b_req_write),
    .req_address    (b_req_address),
    .req_writedata  (b_req_writedata),
    .req_ready      (b_req_ready),
    .rsp_valid      (b_rsp_valid),
    .rsp_readdata   (b_rsp_readdata),
    .pio_address    (b_pio_address),
    .pio_chipselect (b_pio_chipselect),
    .pio_write_n    (b_pio_write_n),
    .pio_writedata  (b_pio_writedata),
    .pio_readdata   (b_pio_readdata),
    .dbg_state      (b_dbg_state)
  );

  // PIO models.
  always @(posedge clk) begin
    a_pio_readdata <= (a_pio_address == 2'd0) ? a_in_port : 32'h0;
    if (a_pio_chipselect && !a_pio_write_n && a_pio_address == 2'd0)
      a_out_port <= a_pio_writedata;
    b_pio_stage    <= (b_pio_address == 2'd0) ? b_in_port : 32'h0;
    b_pio_readdata <= b_pio_stage;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    a_req_valid = '0; a_req_write = '0; a_req_address = '0; a_req_writedata = '0;
    b_req_valid = '0; b_req_write = '0; b_req_address = '0; b_req_writedata = '0;
    a_in_port = 32'h0; b_in_port = 32'h0;

    // ---- reset values ----
    tick(); tick();
    chk("rst_cs",      a_pio_chipselect, 1'b0);
    chk("rst_wn",      a_pio_write_n,    1'b1);
    chk("rst_addr",    a_pio_address,    2'd0);
    chk("rst_wd",      a_pio_writedata,  32'h0);
    chk("rst_ready",   a_req_ready,      2'b00);
    chk("rst_rsp",     a_rsp_valid,      2'b00);
    chk("rst_rdata",   a_rsp_readdata,   32'h0);
    chk("rst_state",   a_dbg_state,      2'd0);
    rst = 1'b0;

    // ---- write from requester 0, addr 0, data 0x5 ----
    a_req_valid = 2'b01; a_req_write = 2'b01; a_req_address = 4'h0;
    a_req_writedata = {32'h0, 32'h5};
    tick();
    chk("wr_cs",    a_pio_chipselect, 1'b1);
    chk("wr_wn",    a_pio_write_n,    1'b0);
    chk("wr_wd",    a_pio_writedata,  32'h5);
    chk("wr_ready", a_req_ready,      2'b01);
    chk("wr_rsp0",  a_rsp_valid,      2'b00);
    a_req_valid = 2'b00;  // dropped after accept; access must still finish
    tick();
    chk("wr_rsp",   a_rsp_valid,      2'b01);
    chk("wr_cs_lo", a_pio_chipselect, 1'b0);
    chk("wr_out",   a_out_port,       32'h5);
    tick();

    // ---- read from requester 1, addr 0, in_port 0xA ----
    a_in_port = 32'hA;
    a_req_valid = 2'b10; a_req_write = 2'b00; a_req_address = {2'd0, 2'd0};
    tick();
    chk("rd_ready", a_req_ready,      2'b10);
    chk("rd_cs",    a_pio_chipselect, 1'b1);
    chk("rd_wn",    a_pio_write_n,    1'b1);
    a_req_valid = 2'b00;
    tick();
    chk("rd_wait_cs",  a_pio_chipselect, 1'b0);
    chk("rd_wait_rsp", a_rsp_valid,      2'b00);
    tick();
    chk("rd_rsp",   a_rsp_valid,    2'b10);
    chk("rd_data",  a_rsp_readdata, 32'h0000000A);
    tick();

    // ---- read from requester 1, addr 1 -> 0 ----
    a_req_valid = 2'b10; a_req_address = {2'd1, 2'd0};
    tick();
    chk("rd1_ready", a_req_ready, 2'b10);
    a_req_valid = 2'b00;
    tick();
    chk("rd1_addr", a_pio_address, 2'd1);
    tick();
    chk("rd1_rsp",  a_rsp_valid,    2'b10);
    chk("rd1_data", a_rsp_readdata, 32'h0);
    tick();

    // ---- both valid continuously: grants alternate 0,1,0,1 ----
    a_req_valid = 2'b11; a_req_write = 2'b11; a_req_address = 4'h0;
    a_req_writedata = {32'h22, 32'h11};
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("alt_ready", a_req_ready,     (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt_wd",    a_pio_writedata, (k % 2 == 0) ? 32'h11 : 32'h22);
      tick();
      chk("alt_rsp",   a_rsp_valid,     (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k == 3) a_req_valid = 2'b00;
      tick();
    end

    // ---- requester 0 alone, 4 back-to-back reads, one per 4 cycles ----
    a_req_valid = 2'b01; a_req_write = 2'b00; a_req_address = 4'h0;
    for (int k = 0; k < 4; k++) begin
      a_in_port = 32'h30 + k;
      tick();
      chk("b2b_ready", a_req_ready, 2'b01);
      tick();
      chk("b2b_wait_addr", a_pio_address,    2'd0);
      chk("b2b_wait_cs",   a_pio_chipselect, 1'b0);
      tick();
      chk("b2b_rsp",  a_rsp_valid,    2'b01);
      chk("b2b_data", a_rsp_readdata, 32'h30 + k);
      if (k == 3) a_req_valid = 2'b00;
      tick();
    end

    // ---- reset during WAIT of a requester-0 read ----
    a_in_port = 32'h99;
    a_req_valid = 2'b01; a_req_write = 2'b00; a_req_address = {2'd0, 2'd2};
    tick();
    chk("mid_ready", a_req_ready, 2'b01);
    a_req_valid = 2'b00;
    tick();
    chk("mid_state", a_dbg_state, 2'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs",    a_pio_chipselect, 1'b0);
    chk("mid_rst_wn",    a_pio_write_n,    1'b1);
    chk("mid_rst_addr",  a_pio_address,    2'd0);
    chk("mid_rst_rsp",   a_rsp_valid,      2'b00);
    chk("mid_rst_rdata", a_rsp_readdata,   32'h0);
    chk("mid_rst_state", a_dbg_state,      2'd0);
    tick();
    chk("mid_rst_rsp2", a_rsp_valid, 2'b00);
    rst = 1'b0;
    tick();
    chk("mid_rst_rsp3", a_rsp_valid, 2'b00);
    a_req_valid = 2'b11; a_req_write = 2'b11; a_req_address = 4'h0;
    a_req_writedata = {32'h55, 32'h44};
    tick();
    chk("post_rst_ready", a_req_ready,     2'b01);
    chk("post_rst_wd",    a_pio_writedata, 32'h44);
    a_req_valid = 2'b00;
    tick();
    chk("post_rst_rsp", a_rsp_valid, 2'b01);
    tick();

    // ---- dut_b: NUM_REQ=3, READ_LATENCY=2, all valid, rotate 0,1,2 ----
    b_in_port = 32'h77;
    b_req_valid = 3'b111; b_req_write = 3'b000;
    b_req_address = {2'd0, 2'd1, 2'd0};
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b_ready", b_req_ready,      3'b001 << k);
      chk("b_cs",    b_pio_chipselect, 1'b1);
      tick();
      chk("b_wait1_rsp", b_rsp_valid, 3'b000);
      tick();
      chk("b_wait2_rsp",  b_rsp_valid,   3'b000);
      chk("b_wait2_addr", b_pio_address, (k == 1) ? 2'd1 : 2'd0);
      tick();
      chk("b_rsp",  b_rsp_valid,    3'b001 << k);
      chk("b_data", b_rsp_readdata, (k == 1) ? 32'h0 : 32'h77);
      if (k == 2) b_req_valid = 3'b000;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
